// File: rtl/micro_sequencer.sv
// Fetch/decode/execute control FSM driving the micro-step decoder, with memory and IO handshakes,
// retired-instruction counter and memory watchdog. Optional single-step mode: MICRO_SEQ_SINGLE_STEP_EN.
module micro_sequencer #(
    parameter int unsigned ICNT_W      = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        ir_op,
    input  logic              mem_ack,
    input  logic              in_valid,
    input  logic              out_ready,
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [2:0]        m2,
    output logic              en,
    output logic              mem_req,
    output logic              mem_we,
    output logic              pc_inc,
    output logic              in_ack,
    output logic              out_valid,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [ICNT_W-1:0] icount
);

    localparam int unsigned WD_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned WD_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_IN    = 3'b101;
    localparam logic [2:0] OP_OUT   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] M2_NOP   = 3'b000;
    localparam logic [2:0] M2_FETCH = 3'b001;
    localparam logic [2:0] M2_STORE = 3'b010;
    localparam logic [2:0] M2_LOAD  = 3'b011;
    localparam logic [2:0] M2_ADD   = 3'b100;
    localparam logic [2:0] M2_SUB   = 3'b101;
    localparam logic [2:0] M2_IN    = 3'b110;
    localparam logic [2:0] M2_OUT   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5,
        S_PAUSE  = 3'd6
    } state_t;

    // Where a retired instruction goes next (single-step parks in PAUSE).
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    localparam state_t RETIRE_ST = S_PAUSE;
`else
    localparam state_t RETIRE_ST = S_FETCH;
`endif

    state_t          state, state_nxt;
    logic [2:0]      op_q, op_nxt;
    logic [WD_W-1:0] wdog, wdog_nxt;
    logic            icnt_inc;
    logic            done;
    logic            wd_hit;

    // This wait cycle is the last one allowed without an ack.
    assign wd_hit = (MEM_TIMEOUT != 0) && (wdog == WD_W'(WD_LAST));

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        icnt_inc  = 1'b0;
        done      = 1'b0;
        m2        = M2_NOP;
        en        = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        pc_inc    = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
        halted    = (state == S_HALT);
        fault     = (state == S_FAULT);

        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                m2      = M2_FETCH;
                mem_req = 1'b1;
                if (mem_ack) begin
                    en        = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wd_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                en     = 1'b1;
                op_nxt = ir_op;
                case (ir_op)
                    OP_NOP: begin
                        icnt_inc  = 1'b1;
                        state_nxt = RETIRE_ST;
                    end
                    OP_HALT: begin
                        icnt_inc  = 1'b1;
                        state_nxt = S_HALT;
                    end
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        m2      = M2_LOAD;
                        mem_req = 1'b1;
                        done    = mem_ack;
                    end
                    OP_STORE: begin
                        m2      = M2_STORE;
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                        done    = mem_ack;
                    end
                    OP_ADD: begin
                        m2   = M2_ADD;
                        done = 1'b1;
                    end
                    OP_SUB: begin
                        m2   = M2_SUB;
                        done = 1'b1;
                    end
                    OP_IN: begin
                        m2     = M2_IN;
                        done   = in_valid;
                        in_ack = in_valid;
                    end
                    OP_OUT: begin
                        m2        = M2_OUT;
                        out_valid = 1'b1;
                        done      = out_ready;
                    end
                    default: done = 1'b0;
                endcase
                en = done;
                if (done) begin
                    icnt_inc  = 1'b1;
                    state_nxt = RETIRE_ST;
                end else if (mem_req && wd_hit) begin
                    state_nxt = S_FAULT;
                end else if (op_q == OP_NOP || op_q == OP_HALT) begin
                    state_nxt = S_FETCH;
                end
            end
`ifdef MICRO_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) state_nxt = S_FETCH;
            end
`endif
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase

        // Watchdog restarts on every state change, counts unanswered request cycles.
        if (state_nxt != state) begin
            wdog_nxt = '0;
        end else if (mem_req && !mem_ack) begin
            wdog_nxt = wdog + WD_W'(1);
        end else begin
            wdog_nxt = wdog;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            wdog   <= '0;
            icount <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            wdog  <= wdog_nxt;
            if (icnt_inc) icount <= icount + ICNT_W'(1);
        end
    end

endmodule
